// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with glitch-free divisor changes and start/stop.
// Optional macro CLK_DIV_MULTI_ALIGN_EN adds an 'align' input that phase-aligns all running channels.
module clk_div_multi #(
    parameter int NCH      = 2,
    parameter int DIV_W    = 8,
    parameter int DIV_INIT = 4,
    localparam int SEL_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             div_wr,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [DIV_W-1:0] div_val,
    input  logic [NCH-1:0]   enable,
`ifdef CLK_DIV_MULTI_ALIGN_EN
    input  logic             align,
`endif
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   stb,
    output logic [NCH-1:0]   running
);

    // Divisors below 2 cannot produce both a high and a low phase, so they run as 2.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    logic align_hit;
`ifdef CLK_DIV_MULTI_ALIGN_EN
    assign align_hit = align;
`else
    assign align_hit = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DIV_W-1:0] cnt_reg;
            logic [DIV_W-1:0] n_reg;
            logic [DIV_W-1:0] p_reg;
            logic             pend_reg;
            logic             run_reg;
            logic             clk_reg;
            logic             stb_reg;
            logic [DIV_W-1:0] hlen;
            logic [DIV_W-1:0] cnt_inc;
            logic [DIV_W-1:0] p_eff;
            logic             wrap;
            logic             wr_hit;

            assign hlen    = (n_reg >> 1) + {{(DIV_W-1){1'b0}}, n_reg[0]};
            assign cnt_inc = cnt_reg + DIV_W'(1);
            assign p_eff   = eff_div(p_reg);
            assign wrap    = (cnt_reg == n_reg - DIV_W'(1));
            // An index equal to gi is necessarily below NCH, so out-of-range writes miss every channel.
            assign wr_hit  = div_wr && (div_sel == SEL_W'(gi));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg  <= DIV_W'(DIV_INIT - 1);
                    n_reg    <= DIV_W'(DIV_INIT);
                    p_reg    <= DIV_W'(DIV_INIT);
                    pend_reg <= 1'b0;
                    run_reg  <= 1'b0;
                    clk_reg  <= 1'b0;
                    stb_reg  <= 1'b0;
                end else begin
                    stb_reg <= 1'b0;
                    if (align_hit && run_reg) begin
                        // Park at the last low cycle so every running channel rises together next cycle.
                        clk_reg <= 1'b0;
                        if (pend_reg) begin
                            n_reg    <= p_eff;
                            cnt_reg  <= p_eff - DIV_W'(1);
                            pend_reg <= 1'b0;
                        end else begin
                            cnt_reg <= n_reg - DIV_W'(1);
                        end
                    end else if (run_reg) begin
                        if (!wrap) begin
                            cnt_reg <= cnt_inc;
                            clk_reg <= (cnt_inc < hlen);
                        end else if (!enable[gi]) begin
                            run_reg <= 1'b0;
                            clk_reg <= 1'b0;
                        end else begin
                            cnt_reg <= '0;
                            clk_reg <= 1'b1;
                            stb_reg <= 1'b1;
                            if (pend_reg) begin
                                n_reg    <= p_eff;
                                pend_reg <= 1'b0;
                            end
                        end
                    end else if (enable[gi]) begin
                        run_reg <= 1'b1;
                        cnt_reg <= '0;
                        clk_reg <= 1'b1;
                        stb_reg <= 1'b1;
                        if (pend_reg) begin
                            n_reg    <= p_eff;
                            pend_reg <= 1'b0;
                        end
                    end else if (pend_reg) begin
                        n_reg    <= p_eff;
                        cnt_reg  <= p_eff - DIV_W'(1);
                        pend_reg <= 1'b0;
                    end
                    // A write landing on an apply edge re-arms pend so the newest value still applies.
                    if (wr_hit) begin
                        p_reg    <= div_val;
                        pend_reg <= 1'b1;
                    end
                end
            end

            assign clk_out[gi] = clk_reg;
            assign stb[gi]     = stb_reg;
            assign running[gi] = run_reg;
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi: start, divisor changes, stop/restart,
// asynchronous reset and out-of-range channel writes.
module tb_clk_div_multi;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       div_wr;
    logic [0:0] div_sel;
    logic [7:0] div_val;
    logic [1:0] enable;
    logic [1:0] clk_out, stb, running;

    logic       div_wr2;
    logic [1:0] div_sel2;
    logic [7:0] div_val2;
    logic [2:0] enable2;
    logic [2:0] clk_out2, stb2, running2;
    logic       align = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int ph0;
    bit t1;

    // Channel 1 over its 29 edges: period 4, then 5 (x3), then divide-by-2.
    logic [0:28] e1_clk = 29'b11001110011100111001010101010;
    logic [0:28] e1_stb = 29'b10001000010000100001010101010;
    logic [0:4]  stop_run = 5'b11000;
    logic [0:4]  rest_clk = 5'b11001;
    logic [0:4]  rest_stb = 5'b10001;

    always #5 clk = ~clk;

    clk_div_multi #(.NCH(2), .DIV_W(8), .DIV_INIT(4)) dut (
        .clk(clk), .reset_n(reset_n), .div_wr(div_wr), .div_sel(div_sel),
        .div_val(div_val), .enable(enable),
`ifdef CLK_DIV_MULTI_ALIGN_EN
        .align(align),
`endif
        .clk_out(clk_out), .stb(stb), .running(running)
    );

    clk_div_multi #(.NCH(3), .DIV_W(8), .DIV_INIT(4)) dut3 (
        .clk(clk), .reset_n(reset_n), .div_wr(div_wr2), .div_sel(div_sel2),
        .div_val(div_val2), .enable(enable2),
`ifdef CLK_DIV_MULTI_ALIGN_EN
        .align(align),
`endif
        .clk_out(clk_out2), .stb(stb2), .running(running2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit hi4(input int ph);
        return (ph % 4) < 2;
    endfunction

    initial begin
        reset_n = 1'b0; div_wr = 1'b0; div_sel = '0; div_val = '0; enable = '0;
        div_wr2 = 1'b0; div_sel2 = '0; div_val2 = '0; enable2 = '0;
        repeat (3) @(posedge clk);
        #3;
        check("rst_clk", 32'(clk_out), 0);
        check("rst_stb", 32'(stb), 0);
        check("rst_run", 32'(running), 0);

        // Channel 0 start with DIV_INIT = 4
        reset_n = 1'b1;
        enable  = 2'b01;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("s1_clk0", 32'(clk_out[0]), 32'(hi4(k - 1)));
            check("s1_stb0", 32'(stb[0]), 32'((k - 1) % 4 == 0));
            check("s1_run", 32'(running), 32'd1);
            $display("s1 cyc %0d clk_out=%b stb=%b running=%b", k, clk_out, stb, running);
        end
        ph0 = 11;

        // Channel 1 divisor writes: 5 mid-period, 0 in the wrap cycle, then 1
        enable = 2'b11;
        for (int e = 0; e <= 28; e++) begin
            step();
            ph0++;
            check("s2_clk0", 32'(clk_out[0]), 32'(hi4(ph0)));
            check("s2_stb0", 32'(stb[0]), 32'(ph0 % 4 == 0));
            check("s2_clk1", 32'(clk_out[1]), 32'(e1_clk[e]));
            check("s2_stb1", 32'(stb[1]), 32'(e1_stb[e]));
            $display("s2 edge %0d clk_out=%b stb=%b", e, clk_out, stb);
            div_wr  = (e == 1) || (e == 13) || (e == 20);
            div_sel = 1'b1;
            div_val = (e == 1) ? 8'd5 : (e == 13) ? 8'd0 : 8'd1;
        end
        div_wr = 1'b0;
        t1 = 1'b1;

        // Stop channel 0 while its count is 1
        while (ph0 % 4 != 1) begin
            step();
            ph0++;
            check("s5_pre_clk0", 32'(clk_out[0]), 32'(hi4(ph0)));
            check("s5_pre_clk1", 32'(clk_out[1]), 32'(t1));
            t1 = ~t1;
        end
        enable[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("s5_stop_clk0", 32'(clk_out[0]), 0);
            check("s5_stop_stb0", 32'(stb[0]), 0);
            check("s5_stop_run0", 32'(running[0]), 32'(stop_run[k]));
            check("s5_stop_clk1", 32'(clk_out[1]), 32'(t1));
            t1 = ~t1;
            $display("s5 stop %0d clk_out=%b stb=%b running=%b", k, clk_out, stb, running);
        end
        enable[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("s5_rest_clk0", 32'(clk_out[0]), 32'(rest_clk[k]));
            check("s5_rest_stb0", 32'(stb[0]), 32'(rest_stb[k]));
            check("s5_rest_run0", 32'(running[0]), 1);
            check("s5_rest_clk1", 32'(clk_out[1]), 32'(t1));
            t1 = ~t1;
            $display("s5 restart %0d clk_out=%b stb=%b running=%b", k, clk_out, stb, running);
        end

        // Asynchronous reset in the high phase, while stb[0] is high
        #2 reset_n = 1'b0;
        #1;
        check("s6_async_clk", 32'(clk_out), 0);
        check("s6_async_stb", 32'(stb), 0);
        check("s6_async_run", 32'(running), 0);
        step();
        step();
        #2 reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("s6_clk", 32'(clk_out), 32'({2{hi4(k - 1)}}));
            check("s6_stb", 32'(stb), 32'({2{(k - 1) % 4 == 0}}));
            check("s6_run", 32'(running), 32'd3);
            $display("s6 cyc %0d clk_out=%b stb=%b running=%b", k, clk_out, stb, running);
        end

        // Out-of-range channel write on a three-channel instance
        div_wr2 = 1'b1; div_sel2 = 2'd3; div_val2 = 8'd2;
        step();
        div_wr2 = 1'b0;
        step();
        check("s4_idle_clk", 32'(clk_out2), 0);
        check("s4_idle_run", 32'(running2), 0);
        enable2 = 3'b111;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("s4_clk", 32'(clk_out2), 32'({3{hi4(k - 1)}}));
            check("s4_stb", 32'(stb2), 32'({3{(k - 1) % 4 == 0}}));
            $display("s4 cyc %0d clk_out=%b stb=%b", k, clk_out2, stb2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
